// File: rtl/clock_ctrl_pkg.sv
// Shared types and widths for the CPU clock-enable controller.
package clock_ctrl_pkg;

  localparam int unsigned CYCLE_W = 8;

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    MANUAL = 2'd1,
    HALT   = 2'd2
  } state_t;

endpackage

// File: rtl/clock_controller_debouncer.sv
// Two-flop synchroniser, stability counter and registered rising-edge pulse
// for a raw asynchronous push button.
module debouncer #(
  parameter int unsigned DB_COUNT = 50000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DB_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic             sync1;
  logic             sync2;
  logic             dout_d;
  logic [CNT_W-1:0] cnt;

  // Synchronise, accept a new level after DB_COUNT disagreeing cycles, pulse on rise
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      dout   <= 1'b0;
      dout_d <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      dout_d <= dout;
      rise   <= dout & ~dout_d;
      if (sync2 != dout) begin
        if (cnt == CNT_LAST) begin
          dout <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_controller.sv
// Run/step/halt clock-enable controller: turns prescaler tick edges or
// debounced step presses into single-cycle cpu_en pulses in the clk_in domain.
module clock_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DB_COUNT = 50000
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               tick_in,
  input  logic               manual,
  input  logic               step_btn,
  input  logic               halt,
  input  logic               resume,
  output logic               cpu_en,
  output logic               halted,
  output logic               clk_led,
  output logic [CYCLE_W-1:0] cycle_cnt
);

  state_t state;
  state_t state_next;

  logic       tick_s1;
  logic       tick_s2;
  logic       tick_prev;
  logic [1:0] tick_fill;
  logic       tick_armed;
  logic       tick_ev;

  logic       btn_stable;
  logic       step_press;
  logic       step_ev;

  logic       resume_d;
  logic       resume_rise;
  logic       pulse_next;

  // Tick edge detection; an edge only counts once a genuine low has been
  // sampled since reset, so a tick already high at reset release is ignored.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick_s1    <= 1'b0;
      tick_s2    <= 1'b0;
      tick_prev  <= 1'b0;
      tick_fill  <= '0;
      tick_armed <= 1'b0;
      tick_ev    <= 1'b0;
    end else begin
      tick_s1    <= tick_in;
      tick_s2    <= tick_s1;
      tick_prev  <= tick_s2;
      tick_fill  <= {tick_fill[0], 1'b1};
      tick_armed <= tick_armed | (tick_fill[1] & ~tick_s2);
      tick_ev    <= tick_s2 & ~tick_prev & tick_armed;
    end
  end

  debouncer #(
    .DB_COUNT(DB_COUNT)
  ) u_step_db (
    .clk_in(clk_in),
    .rst   (rst),
    .din   (step_btn),
    .dout  (btn_stable),
    .rise  (step_press)
  );

  // The rise pulse always falls inside the stable-high window, so gating is a no-op
  assign step_ev = step_press & btn_stable;

  // Resume edge register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      resume_d <= 1'b0;
    end else begin
      resume_d <= resume;
    end
  end

  assign resume_rise = resume & ~resume_d;

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= AUTO;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; halt has priority over everything
  always_comb begin
    state_next = state;
    if (halt) begin
      state_next = HALT;
    end else begin
      case (state)
        HALT: begin
          if (resume_rise) begin
            state_next = manual ? MANUAL : AUTO;
          end
        end
        AUTO: begin
          if (manual) begin
            state_next = MANUAL;
          end
        end
        MANUAL: begin
          if (!manual) begin
            state_next = AUTO;
          end
        end
        default: state_next = AUTO;
      endcase
    end
  end

  // FSM output logic; events coinciding with halt or a mode change are dropped
  always_comb begin
    pulse_next = 1'b0;
    if (!halt) begin
      case (state)
        AUTO:    pulse_next = ~manual & tick_ev;
        MANUAL:  pulse_next = manual & step_ev;
        default: pulse_next = 1'b0;
      endcase
    end
  end

  // Registered outputs: enable pulse, halt flag, LED toggle and pulse counter
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cpu_en    <= 1'b0;
      halted    <= 1'b0;
      clk_led   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cpu_en <= pulse_next;
      halted <= (state_next == HALT);
      if (pulse_next) begin
        clk_led   <= ~clk_led;
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_controller.sv
// Scoreboard bench for clock_controller with DB_COUNT = 4.
module tb_clock_controller;

  localparam int unsigned DB = 4;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       manual;
  logic       step_btn;
  logic       halt;
  logic       resume;
  logic       cpu_en;
  logic       halted;
  logic       clk_led;
  logic [7:0] cycle_cnt;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          exp_n = 0;

  typedef struct {
    int unsigned at;
    logic [7:0]  cnt;
    logic        led;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  clock_controller #(
    .DB_COUNT(DB)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick_in  (tick_in),
    .manual   (manual),
    .step_btn (step_btn),
    .halt     (halt),
    .resume   (resume),
    .cpu_en   (cpu_en),
    .halted   (halted),
    .clk_led  (clk_led),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Record a pulse expected at the given cycle with the counter state it should carry
  task automatic push_pulse(input int unsigned at);
    exp_t e;
    exp_n++;
    e.at  = at;
    e.cnt = 8'(exp_n);
    e.led = exp_n[0];
    exp_q.push_back(e);
  endtask

  // One tick period, called at a negedge; pulse expected 4 cycles after drive
  task automatic tick_period(input int unsigned hi, input int unsigned lo, input bit expect_pulse);
    tick_in = 1'b1;
    if (expect_pulse) push_pulse(cyc + 4);
    repeat (hi) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  // Monitor: compare every pulse against the scoreboard, flag overdue ones
  always @(negedge clk_in) begin
    if (cpu_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cpu_en high at cycle %0d, none required", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.at || cycle_cnt !== mon_e.cnt || clk_led !== mon_e.led) begin
          errors++;
          $display("FAIL pulse: got cycle %0d cnt %0d led %0b, required cycle %0d cnt %0d led %0b",
                   cyc, cycle_cnt, clk_led, mon_e.at, mon_e.cnt, mon_e.led);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
      checks++;
      errors++;
      mon_e = exp_q.pop_front();
      $display("FAIL missing_pulse: none by cycle %0d, required at cycle %0d", cyc, mon_e.at);
    end
  end

  initial begin
    repeat (20000) @(posedge clk_in);
    $display("FAIL watchdog: run exceeded 20000 cycles, got cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    tick_in  = 1'b0;
    manual   = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    resume   = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_halted", halted, 0);
    check("rst_clk_led", clk_led, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);

    // Auto mode: 10 ticks of period 20
    for (int i = 0; i < 10; i++) tick_period(10, 10, 1'b1);
    check("auto_cycle_cnt", cycle_cnt, 10);
    check("auto_clk_led", clk_led, 0);

    // Manual mode: ticks ignored, bouncing button gives one pulse, glitch none
    manual = 1'b1;
    repeat (3) @(negedge clk_in);
    tick_period(10, 10, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step_btn = (i % 2 == 0);
      @(negedge clk_in);
    end
    step_btn = 1'b1;
    push_pulse(cyc + 8);
    repeat (10) @(negedge clk_in);
    step_btn = 1'b0;
    repeat (12) @(negedge clk_in);
    step_btn = 1'b1;
    repeat (3) @(negedge clk_in);
    step_btn = 1'b0;
    repeat (12) @(negedge clk_in);
    check("manual_cycle_cnt", cycle_cnt, 11);
    manual = 1'b0;
    repeat (3) @(negedge clk_in);

    // Halt arriving in the cycle a pulse is due
    tick_in = 1'b1;
    repeat (3) @(negedge clk_in);
    halt = 1'b1;
    @(negedge clk_in);
    check("halt_blocks_pulse", cpu_en, 0);
    check("halted_set", halted, 1);
    repeat (6) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (10) @(negedge clk_in);
    for (int i = 0; i < 5; i++) tick_period(10, 10, 1'b0);
    halt = 1'b0;
    repeat (3) @(negedge clk_in);
    check("halted_without_resume", halted, 1);
    resume = 1'b1;
    repeat (2) @(negedge clk_in);
    check("resume_clears_halted", halted, 0);
    resume = 1'b0;
    repeat (3) @(negedge clk_in);
    tick_period(10, 10, 1'b1);
    check("after_resume_cnt", cycle_cnt, 12);

    // Resume edge while halt still asserted keeps HALT
    halt = 1'b1;
    repeat (2) @(negedge clk_in);
    resume = 1'b1;
    repeat (3) @(negedge clk_in);
    check("resume_under_halt", halted, 1);
    resume = 1'b0;
    halt   = 1'b0;
    repeat (3) @(negedge clk_in);
    check("halt_released_no_edge", halted, 1);
    resume = 1'b1;
    repeat (2) @(negedge clk_in);
    check("second_resume", halted, 0);
    resume = 1'b0;
    repeat (3) @(negedge clk_in);

    // Counter wrap at 256 pulses
    while (exp_n < 256) tick_period(5, 5, 1'b1);
    check("wrap_cycle_cnt", cycle_cnt, 0);
    check("wrap_clk_led", clk_led, 0);
    tick_period(5, 5, 1'b1);
    check("post_wrap_cycle_cnt", cycle_cnt, 1);
    check("post_wrap_clk_led", clk_led, 1);

    // Reset in the cycle cpu_en is high, tick held high across reset
    tick_in = 1'b1;
    push_pulse(cyc + 4);
    repeat (4) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    exp_n = 0;
    check("midrst_cpu_en", cpu_en, 0);
    check("midrst_halted", halted, 0);
    check("midrst_clk_led", clk_led, 0);
    check("midrst_cycle_cnt", cycle_cnt, 0);
    repeat (15) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (10) @(negedge clk_in);
    check("no_pulse_after_rst", cycle_cnt, 0);
    tick_period(10, 10, 1'b1);
    check("auto_after_rst_cnt", cycle_cnt, 1);
    check("auto_after_rst_led", clk_led, 1);

    repeat (10) @(negedge clk_in);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
